// File: rtl/fm_sb_pkg.sv
// Shared constants, types and helpers for the FM spy-buffer writer.
`timescale 1ns/1ps
package fm_sb_pkg;

  localparam int unsigned axi_dw         = 32;
  localparam int unsigned mon_dw_max     = 256;
  localparam int unsigned rec_fifo_depth = 4;
  localparam int unsigned rec_fifo_ptr_w = $clog2(rec_fifo_depth);
  localparam int unsigned rec_fifo_lvl_w = $clog2(rec_fifo_depth + 1);

  typedef enum logic [1:0] {
    PB_SPY        = 2'b00,
    PB_FREEZE     = 2'b01,
    PB_SINGLE     = 2'b10,
    PB_FREEZE_ALT = 2'b11
  } pb_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FROZEN,
    ST_FULL
  } sb_state_e;

  // Record width padded up to a whole number of bus words.
  function automatic int unsigned find_sb_dw(input int unsigned tp_dw, input int unsigned bus_dw);
    return ((tp_dw + bus_dw - 1) / bus_dw) * bus_dw;
  endfunction

endpackage

// File: rtl/fm_sb_rec_fifo.sv
// Four-entry first-word-fall-through record FIFO; push and pop may coincide when full.
`timescale 1ns/1ps
module fm_sb_rec_fifo
  import fm_sb_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [rec_fifo_lvl_w-1:0] level,
  output logic [W-1:0]              rd_data_c
);

  logic [W-1:0]              mem [rec_fifo_depth];
  logic [rec_fifo_ptr_w-1:0] rd_ptr;
  logic [rec_fifo_ptr_w-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + rec_fifo_ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + rec_fifo_ptr_w'(1);
      level <= level + rec_fifo_lvl_w'(push) - rec_fifo_lvl_w'(pop);
    end
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/fm_sb_writer.sv
// Captures monitored FM records into a 32-bit spy-buffer memory in spy,
// freeze or single-shot mode, one record word per cycle.
`timescale 1ns/1ps
module fm_sb_writer
  import fm_sb_pkg::*;
#(
  parameter int unsigned TP_DW  = 51,
  parameter int unsigned SB_DW  = find_sb_dw(TP_DW, axi_dw),
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  spy_clock,
  input  logic                  spy_rst,
  input  logic [mon_dw_max-1:0] fm_data,
  input  logic                  fm_vld,
  input  logic [1:0]            pb_mode,
  input  logic                  sb_clear,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [axi_dw-1:0]     mem_wdata,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic [31:0]           rec_count,
  output logic [15:0]           drop_count,
  output logic                  sb_full,
  output logic                  sb_wrapped,
  output logic                  busy
);

  localparam int unsigned NW    = SB_DW / axi_dw;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BW    = ADDR_W + 2;
  localparam int unsigned CW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned LW    = rec_fifo_lvl_w;

  sb_state_e         state;
  pb_mode_e          mode;
  logic [BW-1:0]     base, base_adv, base_next, load_base;
  logic [CW-1:0]     wcnt;
  logic [SB_DW-1:0]  shreg, rec_in, fifo_head_c;
  logic [LW-1:0]     fifo_level, level_n;
  logic              rst_i, capture_ok, freeze_req, next_over;
  logic              fifo_empty, fifo_full;
  logic              last_word, end_full, accept_c;
  logic              pop_c, push_c, flush_c, drop_c, busy_n;

  assign rst_i      = spy_rst | sb_clear;
  assign mode       = pb_mode_e'(pb_mode);
  assign capture_ok = (mode == PB_SPY) || (mode == PB_SINGLE);
  assign freeze_req = !capture_ok;
  assign rec_in     = SB_DW'(fm_data[TP_DW-1:0]);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(rec_fifo_depth));

  // A record slot is valid only if all NW words fit below DEPTH.
  assign base_adv  = base + BW'(NW);
  assign next_over = (base_adv + BW'(NW)) > BW'(DEPTH);
  assign base_next = next_over ? '0 : base_adv;

  if (TP_DW < mon_dw_max) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^fm_data[mon_dw_max-1:TP_DW];
  end

  // FIFO control: pops happen only at a record boundary.
  always_comb begin
    pop_c     = 1'b0;
    flush_c   = 1'b0;
    accept_c  = 1'b0;
    last_word = (state == ST_WRITE) && (wcnt == CW'(NW - 1));
    end_full  = last_word && (mode == PB_SINGLE) && next_over;
    case (state)
      ST_IDLE: begin
        accept_c = 1'b1;
        if (freeze_req) flush_c = 1'b1;
        else            pop_c   = !fifo_empty;
      end
      ST_WRITE: begin
        accept_c = 1'b1;
        if (last_word) begin
          if (freeze_req || end_full) flush_c = 1'b1;
          else                        pop_c   = !fifo_empty;
        end
      end
      default: flush_c = 1'b1;
    endcase
    push_c    = fm_vld && accept_c && !flush_c && (!fifo_full || pop_c);
    drop_c    = fm_vld && accept_c && !flush_c && fifo_full && !pop_c;
    level_n   = flush_c ? '0 : fifo_level + LW'(push_c) - LW'(pop_c);
    busy_n    = pop_c || ((state == ST_WRITE) && !last_word) || (level_n != '0);
    load_base = (state == ST_WRITE) ? base_next : base;
  end

  fm_sb_rec_fifo #(.W(SB_DW)) u_rec_fifo (
    .clk       (spy_clock),
    .rst       (rst_i),
    .clr       (flush_c),
    .push      (push_c),
    .push_data (rec_in),
    .pop       (pop_c),
    .level     (fifo_level),
    .rd_data_c (fifo_head_c)
  );

  always_ff @(posedge spy_clock) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      base       <= '0;
      wcnt       <= '0;
      shreg      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_ptr     <= '0;
      rec_count  <= '0;
      drop_count <= '0;
      sb_full    <= 1'b0;
      sb_wrapped <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      busy   <= busy_n;
      if (drop_c && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      case (state)
        ST_IDLE: if (freeze_req) state <= ST_FROZEN;
        ST_WRITE: begin
          if (!last_word) begin
            mem_we    <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= shreg[axi_dw-1:0];
            shreg     <= shreg >> axi_dw;
            wcnt      <= wcnt + CW'(1);
          end else begin
            wr_ptr    <= base[ADDR_W-1:0];
            rec_count <= rec_count + 32'd1;
            base      <= base_next;
            if (next_over && !end_full) sb_wrapped <= 1'b1;
            if (end_full) begin
              state   <= ST_FULL;
              sb_full <= 1'b1;
            end else if (freeze_req) begin
              state <= ST_FROZEN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_FROZEN: if (capture_ok) state <= ST_IDLE;
        ST_FULL: begin
          if (mode == PB_SPY) begin
            state   <= ST_IDLE;
            sb_full <= 1'b0;
            base    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Loading a record emits its word 0 on the next cycle, from IDLE or back-to-back.
      if (pop_c) begin
        state     <= ST_WRITE;
        mem_we    <= 1'b1;
        mem_addr  <= load_base[ADDR_W-1:0];
        mem_wdata <= fifo_head_c[axi_dw-1:0];
        shreg     <= fifo_head_c >> axi_dw;
        wcnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fm_sb_writer.sv
// Scoreboard bench for fm_sb_writer: 2-word records (dut_a) and 6-word records (dut_b).
`timescale 1ns/1ps
module tb_fm_sb_writer;
  import fm_sb_pkg::*;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         spy_rst = 1'b1;
  logic         fm_vld = 1'b0;
  logic         sb_clear = 1'b0;
  logic [255:0] fm_data = '0;
  logic [1:0]   pb_mode = 2'b00;

  logic          a_we, a_full, a_wrap, a_busy;
  logic [AW-1:0] a_addr, a_wr_ptr;
  logic [31:0]   a_wdata, a_rec;
  logic [15:0]   a_drop;
  logic          b_we, b_full, b_wrap, b_busy;
  logic [AW-1:0] b_addr, b_wr_ptr;
  logic [31:0]   b_wdata, b_rec;
  logic [15:0]   b_drop;

  fm_sb_writer #(.TP_DW(51), .ADDR_W(AW)) dut_a (
    .spy_clock(clk), .spy_rst(spy_rst), .fm_data(fm_data), .fm_vld(fm_vld),
    .pb_mode(pb_mode), .sb_clear(sb_clear), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .wr_ptr(a_wr_ptr), .rec_count(a_rec), .drop_count(a_drop),
    .sb_full(a_full), .sb_wrapped(a_wrap), .busy(a_busy)
  );

  fm_sb_writer #(.TP_DW(100), .SB_DW(192), .ADDR_W(AW)) dut_b (
    .spy_clock(clk), .spy_rst(spy_rst), .fm_data(fm_data), .fm_vld(fm_vld),
    .pb_mode(pb_mode), .sb_clear(sb_clear), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .wr_ptr(b_wr_ptr), .rec_count(b_rec), .drop_count(b_drop),
    .sb_full(b_full), .sb_wrapped(b_wrap), .busy(b_busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  wr_t         exp_a[$];
  wr_t         exp_b[$];
  int unsigned wcyc_a[$];
  bit          mon_a = 1'b0;
  bit          mon_b = 1'b0;
  int          b_high_writes = 0;
  wr_t         ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-write scoreboard for both DUTs.
  always @(negedge clk) begin
    if (mon_a && a_we) begin
      wcyc_a.push_back(cyc);
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_write unexpected: got addr=%0d data=%h, required no write", a_addr, a_wdata);
      end else begin
        ea = exp_a.pop_front();
        if ({a_addr, a_wdata} !== {ea.addr, ea.data}) begin
          errors++;
          $display("FAIL a_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   a_addr, a_wdata, ea.addr, ea.data);
        end
      end
    end
    if (mon_b && b_we) begin
      if (b_addr >= AW'(30)) b_high_writes++;
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_write unexpected: got addr=%0d data=%h, required no write", b_addr, b_wdata);
      end else begin
        eb = exp_b.pop_front();
        if ({b_addr, b_wdata} !== {eb.addr, eb.data}) begin
          errors++;
          $display("FAIL b_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   b_addr, b_wdata, eb.addr, eb.data);
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input logic [255:0] d, input int tp, input int k);
    logic [255:0] m;
    m = d & ((256'd1 << tp) - 256'd1);
    return 32'(m >> (32 * k));
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [255:0] d);
    fm_data = d;
    fm_vld  = 1'b1;
    tick();
    fm_vld  = 1'b0;
  endtask

  task automatic expect_a(input logic [255:0] d, input int base, input int nwords);
    wr_t e;
    for (int k = 0; k < nwords; k++) begin
      e.addr = AW'(base + k);
      e.data = exp_word(d, 51, k);
      exp_a.push_back(e);
    end
  endtask

  task automatic expect_b(input logic [255:0] d, input int base);
    wr_t e;
    for (int k = 0; k < 6; k++) begin
      e.addr = AW'(base + k);
      e.data = exp_word(d, 100, k);
      exp_b.push_back(e);
    end
  endtask

  task automatic do_reset();
    spy_rst  = 1'b1;
    fm_vld   = 1'b0;
    sb_clear = 1'b0;
    pb_mode  = 2'b00;
    fm_data  = '0;
    idle(2);
    spy_rst  = 1'b0;
    exp_a.delete();
    exp_b.delete();
    wcyc_a.delete();
  endtask

  task automatic test_reset();
    spy_rst = 1'b1;
    fm_vld  = 1'b1;
    fm_data = '1;
    idle(2);
    @(negedge clk);
    checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b, required 0", a_we); end
    checks++; if (a_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0d, required 0", a_addr); end
    checks++; if (a_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h, required 0", a_wdata); end
    checks++; if (a_wr_ptr !== '0) begin errors++; $display("FAIL reset_wr_ptr: got %0d, required 0", a_wr_ptr); end
    checks++; if (a_rec !== 32'd0 || a_drop !== 16'd0) begin errors++; $display("FAIL reset_counts: got rec=%0d drop=%0d, required 0 0", a_rec, a_drop); end
    checks++; if ({a_full, a_wrap, a_busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, required 000", {a_full, a_wrap, a_busy}); end
    checks++; if ({b_we, b_busy} !== 2'b00) begin errors++; $display("FAIL reset_b: got we/busy=%b, required 00", {b_we, b_busy}); end
    fm_vld = 1'b0;
    tick();
  endtask

  task automatic test_first_record();
    int unsigned n;
    logic [255:0] d;
    do_reset();
    mon_a = 1'b1;
    d = '1;
    n = cyc;
    expect_a(d, 0, 2);
    send(d);
    tick();
    @(negedge clk);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b, required 1", a_busy); end
    idle(4);
    checks++;
    if (wcyc_a.size() != 2 || wcyc_a[0] != n + 2 || wcyc_a[1] != n + 3) begin
      errors++;
      $display("FAIL first_latency: got %0d writes, first at offset %0d, required 2 writes at offsets 2,3",
               wcyc_a.size(), (wcyc_a.size() > 0) ? int'(wcyc_a[0] - n) : -1);
    end
    checks++; if (a_rec !== 32'd1 || a_wr_ptr !== '0) begin errors++; $display("FAIL first_done: got rec=%0d wr_ptr=%0d, required 1 0", a_rec, a_wr_ptr); end
    checks++; if (a_busy !== 1'b0 || exp_a.size() != 0) begin errors++; $display("FAIL first_idle: got busy=%b pending=%0d, required 0 0", a_busy, exp_a.size()); end
    mon_a = 1'b0;
  endtask

  task automatic test_spy_wrap();
    logic [255:0] d;
    do_reset();
    mon_a = 1'b1;
    for (int i = 0; i < 17; i++) begin
      d = rand256();
      expect_a(d, (i * 2) % 32, 2);
      send(d);
      idle(4);
      if (i == 14) begin
        checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL spy_wrap_early: got %b, required 0", a_wrap); end
      end
    end
    checks++; if (a_wrap !== 1'b1) begin errors++; $display("FAIL spy_wrapped: got %b, required 1", a_wrap); end
    checks++; if (a_rec !== 32'd17 || a_wr_ptr !== '0) begin errors++; $display("FAIL spy_count: got rec=%0d wr_ptr=%0d, required 17 0", a_rec, a_wr_ptr); end
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL spy_pending: got %0d, required 0", exp_a.size()); end
    mon_a = 1'b0;
  endtask

  task automatic test_single_shot();
    logic [255:0] d;
    do_reset();
    mon_a   = 1'b1;
    pb_mode = 2'b10;
    for (int i = 0; i < 17; i++) begin
      d = rand256();
      if (i < 16) expect_a(d, i * 2, 2);
      send(d);
      idle(4);
      if (i == 14) begin
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL ss_full_early: got %b, required 0", a_full); end
      end
      if (i == 15) begin
        checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL ss_full_16: got %b, required 1", a_full); end
      end
    end
    checks++; if (a_rec !== 32'd16 || a_drop !== 16'd0) begin errors++; $display("FAIL ss_counts: got rec=%0d drop=%0d, required 16 0", a_rec, a_drop); end
    checks++; if (a_full !== 1'b1 || exp_a.size() != 0) begin errors++; $display("FAIL ss_end: got full=%b pending=%0d, required 1 0", a_full, exp_a.size()); end
    pb_mode = 2'b00;
    idle(2);
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL ss_resume_full: got %b, required 0", a_full); end
    d = rand256();
    expect_a(d, 0, 2);
    send(d);
    idle(4);
    checks++; if (a_rec !== 32'd17 || a_wr_ptr !== '0 || exp_a.size() != 0) begin
      errors++; $display("FAIL ss_resume: got rec=%0d wr_ptr=%0d pending=%0d, required 17 0 0", a_rec, a_wr_ptr, exp_a.size());
    end
    mon_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    int j;
    logic [255:0] d;
    do_reset();
    mon_a = 1'b1;
    j = 0;
    n = cyc;
    for (int i = 0; i < 12; i++) begin
      d = rand256();
      if (i != 8 && i != 10) begin
        expect_a(d, j * 2, 2);
        j++;
      end
      fm_data = d;
      fm_vld  = 1'b1;
      tick();
    end
    fm_vld = 1'b0;
    idle(25);
    checks++; if (a_drop !== 16'd2) begin errors++; $display("FAIL b2b_drop: got %0d, required 2", a_drop); end
    checks++; if (a_rec !== 32'd10) begin errors++; $display("FAIL b2b_rec: got %0d, required 10", a_rec); end
    checks++;
    if (wcyc_a.size() != 20 || wcyc_a[0] != n + 2 || wcyc_a[19] != n + 21) begin
      errors++;
      $display("FAIL b2b_gapless: got %0d writes spanning offsets %0d..%0d, required 20 spanning 2..21",
               wcyc_a.size(), (wcyc_a.size() > 0) ? int'(wcyc_a[0] - n) : -1,
               (wcyc_a.size() > 0) ? int'(wcyc_a[wcyc_a.size() - 1] - n) : -1);
    end
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d, required 0", exp_a.size()); end
    mon_a = 1'b0;
  endtask

  task automatic test_nw6();
    logic [255:0] d;
    do_reset();
    mon_b = 1'b1;
    b_high_writes = 0;
    for (int i = 0; i < 6; i++) begin
      d = rand256();
      expect_b(d, (i < 5) ? i * 6 : 0);
      send(d);
      idle(9);
      if (i == 3) begin
        checks++; if (b_wrap !== 1'b0) begin errors++; $display("FAIL nw6_wrap_early: got %b, required 0", b_wrap); end
      end
    end
    checks++; if (b_wrap !== 1'b1) begin errors++; $display("FAIL nw6_wrapped: got %b, required 1", b_wrap); end
    checks++; if (b_rec !== 32'd6 || b_wr_ptr !== '0) begin errors++; $display("FAIL nw6_count: got rec=%0d wr_ptr=%0d, required 6 0", b_rec, b_wr_ptr); end
    checks++; if (b_high_writes != 0 || exp_b.size() != 0) begin
      errors++; $display("FAIL nw6_tail: got high_writes=%0d pending=%0d, required 0 0", b_high_writes, exp_b.size());
    end
    mon_b = 1'b0;
  endtask

  task automatic test_freeze_clear();
    logic [255:0] d;
    do_reset();
    mon_a = 1'b1;
    d = rand256();
    expect_a(d, 0, 2);
    fm_data = d;
    fm_vld  = 1'b1;
    tick();
    fm_data = rand256();
    tick();
    fm_data = rand256();
    pb_mode = 2'b01;
    tick();
    fm_vld = 1'b0;
    idle(4);
    send(rand256());
    idle(3);
    checks++; if (a_rec !== 32'd1 || exp_a.size() != 0) begin errors++; $display("FAIL frz_complete: got rec=%0d pending=%0d, required 1 0", a_rec, exp_a.size()); end
    checks++; if (a_busy !== 1'b0 || a_drop !== 16'd0) begin errors++; $display("FAIL frz_flushed: got busy=%b drop=%0d, required 0 0", a_busy, a_drop); end
    pb_mode = 2'b00;
    idle(6);
    checks++; if (a_rec !== 32'd1 || a_busy !== 1'b0) begin errors++; $display("FAIL frz_resume: got rec=%0d busy=%b, required 1 0", a_rec, a_busy); end
    d = rand256();
    expect_a(d, 2, 1);
    send(d);
    tick();
    sb_clear = 1'b1;
    tick();
    sb_clear = 1'b0;
    @(negedge clk);
    checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL clr_we: got %b, required 0", a_we); end
    checks++; if (a_rec !== 32'd0 || a_wr_ptr !== '0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL clr_state: got rec=%0d wr_ptr=%0d busy=%b, required 0 0 0", a_rec, a_wr_ptr, a_busy);
    end
    idle(4);
    checks++; if (exp_a.size() != 0 || a_drop !== 16'd0) begin errors++; $display("FAIL clr_after: got pending=%0d drop=%0d, required 0 0", exp_a.size(), a_drop); end
    mon_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_record();
    test_spy_wrap();
    test_single_shot();
    test_back_to_back();
    test_nw6();
    test_freeze_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
